// File: rtl/selector_input_arbiter.sv
// selector_input_arbiter
//   Shares one selector between NUM_INPUTS requesters. Arbitration is round-robin
//   at packet granularity: a winner keeps the selector until its end-of-packet
//   word. Granted words reach the selector through one register stage. The
//   selector has no backpressure, so the output never stalls.
//
// Optional feature (compile-time macro SELECTOR_ARB_WATCHDOG_EN):
//   An idle watchdog in LOCKED abandons a packet after TIMEOUT owner-idle cycles
//   and pulses timeout_err. Without the macro, timeout_err is tied to 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   in_valid     per-requester word valid
//   in_eop       per-requester end-of-packet, qualified by in_valid
//   in_ctl       packed control words, requester i at [i*CTRL_WIDTH +: CTRL_WIDTH]
//   in_data      packed data words, same packing as in_ctl
//   in_ready     per-requester accept (combinational)
//   datavalid    registered word valid to the selector
//   out_ctl      registered control word
//   out_data     registered data word
//   owner        index of the current or last owner
//   busy         high while a packet owns the selector
//   timeout_err  one-cycle watchdog pulse
module selector_input_arbiter #(
  parameter int unsigned DATA_WIDTH = 480,
  parameter int unsigned CTRL_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_eop,
  input  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctl,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             datavalid,
  output logic [CTRL_WIDTH-1:0]            out_ctl,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [IDX_WIDTH-1:0]             owner,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int unsigned CNT_WIDTH = 8;

  // Reject configurations the index/counter widths cannot represent
  if (NUM_INPUTS < 2 || NUM_INPUTS > 8 || IDX_WIDTH != $clog2(NUM_INPUTS) ||
      TIMEOUT < 1 || TIMEOUT > 256) begin : g_param_check
    $error("selector_input_arbiter: unsupported parameter set");
  end

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [IDX_WIDTH-1:0] rr_ptr, rr_next, owner_next;
  logic [IDX_WIDTH-1:0] winner, cand;
  logic                 found;
  logic                 xfer, eop_xfer;
  logic [CTRL_WIDTH-1:0] ctl_mux;
  logic [DATA_WIDTH-1:0] data_mux;

  // Modulo-NUM_INPUTS increment (NUM_INPUTS need not be a power of two)
  function automatic logic [IDX_WIDTH-1:0] inc_idx(input logic [IDX_WIDTH-1:0] i);
    if (i == IDX_WIDTH'(NUM_INPUTS - 1)) return '0;
    else return i + IDX_WIDTH'(1);
  endfunction

  // Round-robin scan starting at rr_ptr
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = rr_ptr;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      if (!found && in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = inc_idx(cand);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      owner  <= owner_next;
    end
  end

`ifdef SELECTOR_ARB_WATCHDOG_EN
  logic [CNT_WIDTH-1:0] idle_cnt;
  logic                 timeout_hit;
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    owner_next = owner;
`ifdef SELECTOR_ARB_WATCHDOG_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          owner_next = winner;
          if (eop_xfer) rr_next = inc_idx(winner);
          else          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (eop_xfer) begin
          state_next = IDLE;
          rr_next    = inc_idx(owner);
        end
`ifdef SELECTOR_ARB_WATCHDOG_EN
        // Last allowed idle cycle: abandon the packet
        else if (!xfer && idle_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
          state_next  = IDLE;
          rr_next     = inc_idx(owner);
          timeout_hit = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: grant, transfer qualifiers, word mux
  always_comb begin
    in_ready = '0;
    case (state)
      IDLE:    if (found) in_ready[winner] = 1'b1;
      LOCKED:  in_ready[owner] = 1'b1;
      default: in_ready = '0;
    endcase
    xfer     = |(in_valid & in_ready);
    eop_xfer = |(in_valid & in_eop & in_ready);
    // in_ready is one-hot, so an AND-OR mux suffices
    ctl_mux  = '0;
    data_mux = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      ctl_mux  = ctl_mux  | ({CTRL_WIDTH{in_ready[i]}} & in_ctl[i*CTRL_WIDTH +: CTRL_WIDTH]);
      data_mux = data_mux | ({DATA_WIDTH{in_ready[i]}} & in_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign busy = (state == LOCKED);

  // Output register stage; data holds across non-transfer cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      datavalid <= 1'b0;
      out_ctl   <= '0;
      out_data  <= '0;
    end else begin
      datavalid <= xfer;
      if (xfer) begin
        out_ctl  <= ctl_mux;
        out_data <= data_mux;
      end
    end
  end

`ifdef SELECTOR_ARB_WATCHDOG_EN
  // Idle counter: counts owner-idle cycles in LOCKED, clears otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state == LOCKED && !xfer && !timeout_hit) idle_cnt <= idle_cnt + CNT_WIDTH'(1);
      else                                          idle_cnt <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_selector_input_arbiter.sv
module tb_selector_input_arbiter;

  localparam int unsigned DW = 480;
  localparam int unsigned CW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_eop;
  logic [N*CW-1:0] in_ctl;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            datavalid;
  logic [CW-1:0]   out_ctl;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   owner;
  logic            busy;
  logic            timeout_err;

  selector_input_arbiter #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(N), .IDX_WIDTH(IW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_eop(in_eop), .in_ctl(in_ctl),
    .in_data(in_data), .in_ready(in_ready), .datavalid(datavalid), .out_ctl(out_ctl),
    .out_data(out_data), .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctl;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] v;
    logic [3:0] e;
    logic [3:0] rdy;
    logic       busy;
    logic [1:0] own;
  } vec_t;

  exp_t          q[$];
  vec_t          vecs[21];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] last_ctl = '0;

  function automatic logic [CW-1:0] ctl_of(input int k, input int i);
    return CW'(k * 16 + i);
  endfunction

  function automatic logic [DW-1:0] data_of(input int k, input int i);
    logic [CW-1:0] c;
    c = ctl_of(k, i) ^ 32'hDEAD_0000;
    return {15{c}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check grant, push expectation, check outputs after posedge
  task automatic step(input logic [3:0] v, input logic [3:0] e, input logic [3:0] rdy,
                      input logic busy_e, input logic [1:0] own_e, input logic to_e,
                      input int k);
    exp_t item;
    int   idx;
    logic exp_dv;
    @(negedge clk);
    in_valid = v;
    in_eop   = e;
    for (int i = 0; i < int'(N); i++) begin
      in_ctl[i*CW +: CW]  = ctl_of(k, i);
      in_data[i*DW +: DW] = data_of(k, i);
    end
    #1;
    check($sformatf("in_ready[k=%0d]", k), 512'(in_ready), 512'(rdy));
    if ((v & rdy) != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < int'(N); i++) if (rdy[i]) idx = i;
      item.ctl  = ctl_of(k, idx);
      item.data = data_of(k, idx);
      q.push_back(item);
    end
    @(posedge clk);
    #1;
    exp_dv = (q.size() != 0);
    check($sformatf("datavalid[k=%0d]", k), 512'(datavalid), 512'(exp_dv));
    if (exp_dv) begin
      item = q.pop_front();
      check($sformatf("out_ctl[k=%0d]", k), 512'(out_ctl), 512'(item.ctl));
      check($sformatf("out_data[k=%0d]", k), 512'(out_data), 512'(item.data));
      last_ctl = item.ctl;
    end else begin
      check($sformatf("out_ctl_hold[k=%0d]", k), 512'(out_ctl), 512'(last_ctl));
    end
    check($sformatf("busy[k=%0d]", k), 512'(busy), 512'(busy_e));
    check($sformatf("owner[k=%0d]", k), 512'(owner), 512'(own_e));
    check($sformatf("timeout_err[k=%0d]", k), 512'(timeout_err), 512'(to_e));
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    //           valid    eop      ready    busy  owner
    vecs[0]  = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd1};  // single-word from req1
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1};  // nothing valid
    vecs[2]  = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd3};  // rr 2 -> 3 wins, wraps to 0
    vecs[3]  = '{4'b1111, 4'b1111, 4'b0001, 1'b0, 2'd0};  // all valid: 0,1,2,3,0,1,2,3
    vecs[4]  = '{4'b1111, 4'b1111, 4'b0010, 1'b0, 2'd1};
    vecs[5]  = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 2'd2};
    vecs[6]  = '{4'b1111, 4'b1111, 4'b1000, 1'b0, 2'd3};
    vecs[7]  = '{4'b1111, 4'b1111, 4'b0001, 1'b0, 2'd0};
    vecs[8]  = '{4'b1111, 4'b1111, 4'b0010, 1'b0, 2'd1};
    vecs[9]  = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 2'd2};
    vecs[10] = '{4'b1111, 4'b1111, 4'b1000, 1'b0, 2'd3};
    vecs[11] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0};  // rr -> 1
    vecs[12] = '{4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2};  // req2 3-word packet, req0 waits
    vecs[13] = '{4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2};
    vecs[14] = '{4'b0101, 4'b0100, 4'b0100, 1'b0, 2'd2};
    vecs[15] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0};  // req0 right after eop
    vecs[16] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1};  // req1 multi-word
    vecs[17] = '{4'b1101, 4'b0010, 4'b0010, 1'b1, 2'd1};  // bubble; eop without valid ignored
    vecs[18] = '{4'b1101, 4'b0000, 4'b0010, 1'b1, 2'd1};  // bubble
    vecs[19] = '{4'b1111, 4'b0010, 4'b0010, 1'b0, 2'd1};  // owner eop
    vecs[20] = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2};  // req2 starts packet

    rst      = 1'b0;
    in_valid = '0;
    in_eop   = '0;
    in_ctl   = '0;
    in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_datavalid", 512'(datavalid), 512'(0));
    check("reset_out_ctl", 512'(out_ctl), 512'(0));
    check("reset_out_data", 512'(out_data), 512'(0));
    check("reset_busy", 512'(busy), 512'(0));
    check("reset_owner", 512'(owner), 512'(0));
    check("reset_timeout_err", 512'(timeout_err), 512'(0));
    check("reset_in_ready", 512'(in_ready), 512'(0));
    rst = 1'b1;

    for (int n = 0; n < 21; n++)
      step(vecs[n].v, vecs[n].e, vecs[n].rdy, vecs[n].busy, vecs[n].own, 1'b0, n + 1);

    // Asynchronous reset mid-packet: outputs clear without a clock edge
    @(negedge clk);
    in_valid = 4'b0100;
    in_eop   = 4'b0000;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_datavalid", 512'(datavalid), 512'(0));
    check("midrst_out_ctl", 512'(out_ctl), 512'(0));
    check("midrst_out_data", 512'(out_data), 512'(0));
    check("midrst_busy", 512'(busy), 512'(0));
    check("midrst_owner", 512'(owner), 512'(0));
    q.delete();
    last_ctl = '0;
    in_valid = '0;
    #1;
    rst = 1'b1;
    // Arbitration restarts from requester 0
    step(4'b1111, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b0, 100);

`ifdef SELECTOR_ARB_WATCHDOG_EN
    // Owner goes idle for TIMEOUT=4 cycles; packet abandoned, next requester wins
    step(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 101);
    step(4'b1011, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 102);
    step(4'b1011, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 103);
    step(4'b1011, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 104);
    step(4'b1011, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b1, 105);
    step(4'b1011, 4'b1011, 4'b1000, 1'b0, 2'd3, 1'b0, 106);
`endif

    step(4'b0000, 4'b0000, 4'b0000, 1'b0, owner, 1'b0, 200);
    check("scoreboard_empty", 512'(q.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/selector_input_arbiter.md
Name: selector_input_arbiter

Overview:
- Shares one selector instance between NUM_INPUTS upstream requesters (per-port parsers/DMA).
- Round-robin arbitration at packet granularity. Once a requester wins, it owns the selector until it presents its end-of-packet word.
- Drives the selector's datavalid/in_ctl/in_data through one register stage.
- The selector has no backpressure, so the arbiter never stalls its output.

Parameters:
- DATA_WIDTH, 480, width of one data word.
- CTRL_WIDTH, 32, width of one control word.
- NUM_INPUTS, 4, number of requesters; must be 2..8.
- IDX_WIDTH, 2, log2(NUM_INPUTS), minimum 1.
- TIMEOUT, 255, watchdog idle-cycle limit; used only with the watchdog feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_INPUTS  per-requester word valid.
- in_eop  in  NUM_INPUTS  per-requester end-of-packet flag, qualified by in_valid.
- in_ctl  in  NUM_INPUTS*CTRL_WIDTH  packed control words; requester i occupies [i*CTRL_WIDTH +: CTRL_WIDTH].
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed data words, same packing as in_ctl.
- in_ready  out  NUM_INPUTS  per-requester accept, combinational.
- datavalid  out  1  registered word valid to the selector.
- out_ctl  out  CTRL_WIDTH  registered control to the selector.
- out_data  out  DATA_WIDTH  registered data to the selector.
- owner  out  IDX_WIDTH  index of the current or last owner.
- busy  out  1  high in state LOCKED.
- timeout_err  out  1  one-cycle watchdog pulse; tied 0 when the feature is absent.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0.
  - datavalid=0, out_ctl=0, out_data=0, timeout_err=0, idle counter=0.
- Transfer rule: a word moves from requester i when in_valid[i] & in_ready[i].
  - The following cycle: datavalid=1, out_ctl=in_ctl[i], out_data=in_data[i].
  - Latency is exactly 1 cycle.
  - On any cycle without a transfer: datavalid=0, out_ctl/out_data hold their previous values.
- State IDLE:
  - Winner = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS.
  - in_ready is one-hot on the winner in the same cycle (zero-bubble grant); the first word transfers in that cycle.
  - owner <= winner.
  - If that word has in_eop=1 (single-word packet): stay IDLE, rr_ptr <= winner+1 (mod NUM_INPUTS).
  - Otherwise go to LOCKED.
  - No in_valid set: in_ready=0, no transfer.
- State LOCKED:
  - in_ready = one-hot on owner, all other bits 0; other requesters wait regardless of their valid.
  - Each owner word with in_valid=1 transfers.
  - Owner word with in_eop=1: go to IDLE, rr_ptr <= owner+1 (mod NUM_INPUTS).
  - Owner in_valid=0: bubble; datavalid=0 next cycle, stay LOCKED.
- Wrap-around: rr_ptr = NUM_INPUTS-1 wraps to 0.
- Simultaneous requests: the round-robin order decides; no requester wins twice in a row while another is waiting.
- Back-to-back packets: the cycle after an eop is IDLE and arbitrates immediately; no dead cycle is inserted.
- Reset mid-packet: the packet is dropped. The arbiter does not flag it; the requester is responsible for restarting.
- in_eop without in_valid is ignored.
- busy = (state==LOCKED).

Optional Feature:
- Macro: SELECTOR_ARB_WATCHDOG_EN.
- When defined:
  - An 8-bit idle counter runs in LOCKED; it counts cycles with owner in_valid=0 and clears on every owner transfer.
  - When the counter reaches TIMEOUT: force state to IDLE, rr_ptr <= owner+1, pulse timeout_err=1 for one cycle, clear the counter.
  - Words from the abandoned packet arriving later are arbitrated as a new packet.
- When not defined: no counter exists, timeout_err is constant 0, and LOCKED persists until eop.

Test Plan:
- Reset, then in_valid=4'b0010 with a single word (eop=1, ctl=32'h11) -> in_ready=4'b0010 the same cycle; next cycle datavalid=1, out_ctl=32'h11; rr_ptr=2.
- All four valid with single-word packets held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; datavalid continuously 1.
- Requester 2 sends a 3-word packet (eop on word 3) while requester 0 stays valid -> in_ready[0]=0 for all 3 words; req0 granted the cycle after eop; out_data sequence is req2 w1,w2,w3 then req0.
- Owner bubble: requester 1 drops in_valid for 2 cycles mid-packet -> datavalid=0 for those cycles, busy=1, owner=1, no other grant.
- Assert rst low mid-packet -> datavalid/out_ctl/out_data=0 and busy=0 immediately (asynchronous); after release, arbitration restarts from requester 0.
- With SELECTOR_ARB_WATCHDOG_EN and TIMEOUT=4: owner goes idle mid-packet -> timeout_err pulses 1 cycle after 4 idle cycles, busy=0, the next requester is granted.
